asrv32_writeback: RTL and testbench



---
 rtl/asrv32_pkg.sv | 28 ++
 rtl/asrv32_load_ext.sv | 39 +++
 rtl/asrv32_writeback.sv | 139 +++++++++++++
 tb/tb_asrv32_writeback.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/asrv32_pkg.sv
// Shared definitions for the ASRV32 writeback stage: load funct3 codes,
// FSM state encoding and the load alignment rule.
package asrv32_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } wb_state_t;

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic load_misaligned(input logic [2:0] funct3,
                                             input logic [1:0] lsb);
        logic w_mis;
        w_mis = 1'b0;
        if ((funct3 == FUNCT3_LH) || (funct3 == FUNCT3_LHU))
            w_mis = lsb[0];
        else if (funct3 == FUNCT3_LW)
            w_mis = (lsb != 2'b00);
        return w_mis;
    endfunction

endpackage

// File: rtl/asrv32_load_ext.sv
// Combinational load data alignment: picks the addressed byte/halfword from
// the raw memory word and sign- or zero-extends it to 32 bits.
module asrv32_load_ext
    import asrv32_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lsb,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_lsb)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_lsb[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Unknown load types still retire, but deliver zero.
    always_comb begin
        o_data = 32'd0;
        case (i_funct3)
            FUNCT3_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            FUNCT3_LH:  o_data = {{16{w_half[15]}}, w_half};
            FUNCT3_LW:  o_data = i_rdata;
            FUNCT3_LBU: o_data = {24'd0, w_byte};
            FUNCT3_LHU: o_data = {16'd0, w_half};
            default:    o_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/asrv32_writeback.sv
// ASRV32 writeback stage: accepts completed instructions, waits for load data,
// and drives one registered register-file write per instruction; counts retires.
module asrv32_writeback
    import asrv32_pkg::*;
#(
    parameter logic [31:0] RESET_INSTRET = 32'd0
)(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ex_valid,
    output logic        o_ex_ready,
    input  logic        i_ex_rd_we,
    input  logic [4:0]  i_ex_rd_addr,
    input  logic [31:0] i_ex_result,
    input  logic        i_ex_is_load,
    input  logic [2:0]  i_ex_funct3,
    input  logic [1:0]  i_ex_addr_lsb,
    input  logic        i_flush,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_ce_wr,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd_data,
    output logic        o_misaligned,
    output logic [31:0] o_instret
);

    wb_state_t   r_state;
    wb_state_t   w_next_state;
    logic        r_kill;
    logic        r_ld_we;
    logic [4:0]  r_ld_rd;
    logic [2:0]  r_ld_funct3;
    logic [1:0]  r_ld_lsb;
    logic        r_ce_wr;
    logic [4:0]  r_rd_addr;
    logic [31:0] r_rd_data;
    logic        r_misaligned;
    logic [31:0] r_instret;
    logic [31:0] w_ext_data;
    logic        w_accept;
    logic        w_mis;
    logic        w_ld_done;
    logic        w_killed;

    asrv32_load_ext u_load_ext (
        .i_funct3 (r_ld_funct3),
        .i_lsb    (r_ld_lsb),
        .i_rdata  (i_mem_rdata),
        .o_data   (w_ext_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    // Handshake: an instruction transfers on a cycle where i_ex_valid and
    // o_ex_ready are both high; ready is high exactly while in IDLE.
    always_comb begin
        w_next_state = r_state;
        o_ex_ready   = 1'b0;
        w_accept     = 1'b0;
        w_mis        = 1'b0;
        w_ld_done    = 1'b0;
        w_killed     = r_kill | i_flush;
        case (r_state)
            ST_IDLE: begin
                o_ex_ready = 1'b1;
                w_accept   = i_ex_valid;
                if (i_ex_valid && i_ex_is_load) begin
                    w_mis = load_misaligned(i_ex_funct3, i_ex_addr_lsb);
                    if (!w_mis) w_next_state = ST_LOAD_WAIT;
                end
            end
            ST_LOAD_WAIT: begin
                if (i_mem_ack) begin
                    w_ld_done    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_kill      <= 1'b0;
            r_ld_we     <= 1'b0;
            r_ld_rd     <= 5'd0;
            r_ld_funct3 <= 3'd0;
            r_ld_lsb    <= 2'd0;
        end else begin
            if (w_accept && i_ex_is_load) begin
                r_ld_we     <= i_ex_rd_we;
                r_ld_rd     <= i_ex_rd_addr;
                r_ld_funct3 <= i_ex_funct3;
                r_ld_lsb    <= i_ex_addr_lsb;
            end
            if (w_ld_done)
                r_kill <= 1'b0;
            else if ((r_state == ST_LOAD_WAIT) && i_flush)
                r_kill <= 1'b1;
        end
    end

    // Outputs are registered so each strobe is a clean single-cycle pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ce_wr      <= 1'b0;
            r_rd_addr    <= 5'd0;
            r_rd_data    <= 32'd0;
            r_misaligned <= 1'b0;
            r_instret    <= RESET_INSTRET;
        end else begin
            r_ce_wr      <= 1'b0;
            r_misaligned <= w_mis;
            if (w_accept && !i_ex_is_load) begin
                r_ce_wr   <= i_ex_rd_we && (i_ex_rd_addr != 5'd0);
                r_rd_addr <= i_ex_rd_addr;
                r_rd_data <= i_ex_result;
                r_instret <= r_instret + 32'd1;
            end
            if (w_ld_done && !w_killed) begin
                r_ce_wr   <= r_ld_we && (r_ld_rd != 5'd0);
                r_rd_addr <= r_ld_rd;
                r_rd_data <= w_ext_data;
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    assign o_ce_wr      = r_ce_wr;
    assign o_rd_addr    = r_rd_addr;
    assign o_rd_data    = r_rd_data;
    assign o_misaligned = r_misaligned;
    assign o_instret    = r_instret;

endmodule

// File: tb/tb_asrv32_writeback.sv
// Directed bench for asrv32_writeback: expected register writes are queued
// when stimulus is driven and matched by a monitor as the DUT writes back.
module tb_asrv32_writeback;

    localparam logic [31:0] RST_INSTRET = 32'hFFFF_FFFE;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_ex_valid;
    logic        o_ex_ready;
    logic        i_ex_rd_we;
    logic [4:0]  i_ex_rd_addr;
    logic [31:0] i_ex_result;
    logic        i_ex_is_load;
    logic [2:0]  i_ex_funct3;
    logic [1:0]  i_ex_addr_lsb;
    logic        i_flush;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_ce_wr;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_misaligned;
    logic [31:0] o_instret;

    int          n_pass;
    int          n_total;
    int          mis_pend;
    logic [31:0] exp_instret;
    logic [36:0] exp_q[$];

    asrv32_writeback #(.RESET_INSTRET(RST_INSTRET)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_ex_valid    (i_ex_valid),
        .o_ex_ready    (o_ex_ready),
        .i_ex_rd_we    (i_ex_rd_we),
        .i_ex_rd_addr  (i_ex_rd_addr),
        .i_ex_result   (i_ex_result),
        .i_ex_is_load  (i_ex_is_load),
        .i_ex_funct3   (i_ex_funct3),
        .i_ex_addr_lsb (i_ex_addr_lsb),
        .i_flush       (i_flush),
        .i_mem_ack     (i_mem_ack),
        .i_mem_rdata   (i_mem_rdata),
        .o_ce_wr       (o_ce_wr),
        .o_rd_addr     (o_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_misaligned  (o_misaligned),
        .o_instret     (o_instret)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Scoreboard: every write strobe must match the oldest queued expectation.
    always @(negedge i_clk) begin
        logic [36:0] e;
        if (o_ce_wr) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {31'd0, o_ce_wr}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {27'd0, o_rd_addr}, {27'd0, e[36:32]});
                chk("wr_data", o_rd_data, e[31:0]);
            end
        end
        if (o_misaligned) begin
            chk("mis_pulse_expected", {31'd0, o_misaligned}, {31'd0, (mis_pend > 0)});
            if (mis_pend > 0) mis_pend--;
        end
    end

    task automatic after_op(input string tag);
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_mis_drained"}, 32'(mis_pend), 32'd0);
        chk({tag, "_instret"}, o_instret, exp_instret);
        chk({tag, "_ce_wr_low"}, {31'd0, o_ce_wr}, 32'd0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            if (o_ex_ready) break;
            tick();
        end
        chk("ready_wait", {31'd0, o_ex_ready}, 32'd1);
    endtask

    task automatic send_alu(input logic we, input logic [4:0] rd, input logic [31:0] res);
        wait_ready();
        i_ex_valid   = 1'b1;
        i_ex_is_load = 1'b0;
        i_ex_rd_we   = we;
        i_ex_rd_addr = rd;
        i_ex_result  = res;
        if (we && (rd != 5'd0)) exp_q.push_back({rd, res});
        exp_instret = exp_instret + 32'd1;
        tick();
        i_ex_valid = 1'b0;
        tick();
        after_op("alu");
    endtask

    task automatic send_load(input logic [2:0] f3, input logic [1:0] lsb,
                             input logic [4:0] rd, input logic we, input logic mis);
        wait_ready();
        i_ex_valid    = 1'b1;
        i_ex_is_load  = 1'b1;
        i_ex_funct3   = f3;
        i_ex_addr_lsb = lsb;
        i_ex_rd_addr  = rd;
        i_ex_rd_we    = we;
        if (mis) mis_pend++;
        tick();
        i_ex_valid   = 1'b0;
        i_ex_is_load = 1'b0;
        chk("ready_after_load", {31'd0, o_ex_ready}, {31'd0, mis});
        if (mis) begin
            tick();
            after_op("misaligned");
        end
    endtask

    task automatic mem_ack(input int gap, input logic [31:0] rdata, input logic flush_now,
                           input logic wr, input logic retire,
                           input logic [4:0] rd, input logic [31:0] data);
        repeat (gap - 1) tick();
        i_mem_ack   = 1'b1;
        i_mem_rdata = rdata;
        i_flush     = flush_now;
        if (wr) exp_q.push_back({rd, data});
        if (retire) exp_instret = exp_instret + 32'd1;
        tick();
        i_mem_ack = 1'b0;
        i_flush   = 1'b0;
        chk("ready_after_ack", {31'd0, o_ex_ready}, 32'd1);
        tick();
        after_op("load");
    endtask

    initial begin
        n_pass = 0; n_total = 0; mis_pend = 0;
        exp_instret = RST_INSTRET;
        i_rst_n = 1'b0; i_ex_valid = 1'b0; i_ex_rd_we = 1'b0; i_ex_rd_addr = 5'd0;
        i_ex_result = 32'd0; i_ex_is_load = 1'b0; i_ex_funct3 = 3'd0; i_ex_addr_lsb = 2'd0;
        i_flush = 1'b0; i_mem_ack = 1'b0; i_mem_rdata = 32'd0;
        repeat (3) tick();
        chk("rst_ce_wr", {31'd0, o_ce_wr}, 32'd0);
        chk("rst_rd_addr", {27'd0, o_rd_addr}, 32'd0);
        chk("rst_rd_data", o_rd_data, 32'd0);
        chk("rst_misaligned", {31'd0, o_misaligned}, 32'd0);
        chk("rst_ready", {31'd0, o_ex_ready}, 32'd1);
        chk("rst_instret", o_instret, RST_INSTRET);
        i_rst_n = 1'b1;
        tick();

        send_alu(1'b1, 5'd5, 32'h1234_5678);
        send_alu(1'b1, 5'd0, 32'hAAAA_5555);
        chk("instret_wrap", o_instret, 32'd0);
        send_alu(1'b0, 5'd7, 32'h0BAD_F00D);

        // Stray ack while idle must not produce a write.
        i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
        tick();
        i_mem_ack = 1'b0;
        tick();
        after_op("idle_ack");

        send_load(3'b000, 2'd3, 5'd10, 1'b1, 1'b0);
        mem_ack(3, 32'h80AA_BBCC, 1'b0, 1'b1, 1'b1, 5'd10, 32'hFFFF_FF80);
        send_load(3'b100, 2'd3, 5'd11, 1'b1, 1'b0);
        mem_ack(3, 32'h80AA_BBCC, 1'b0, 1'b1, 1'b1, 5'd11, 32'h0000_0080);
        send_load(3'b001, 2'd2, 5'd12, 1'b1, 1'b0);
        mem_ack(3, 32'h80AA_BBCC, 1'b0, 1'b1, 1'b1, 5'd12, 32'hFFFF_80AA);
        send_load(3'b101, 2'd0, 5'd13, 1'b1, 1'b0);
        mem_ack(1, 32'h1234_8765, 1'b0, 1'b1, 1'b1, 5'd13, 32'h0000_8765);
        send_load(3'b010, 2'd0, 5'd14, 1'b1, 1'b0);
        mem_ack(2, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 5'd14, 32'hDEAD_BEEF);
        send_load(3'b000, 2'd1, 5'd15, 1'b1, 1'b0);
        mem_ack(1, 32'h0000_7F00, 1'b0, 1'b1, 1'b1, 5'd15, 32'h0000_007F);
        send_load(3'b011, 2'd0, 5'd16, 1'b1, 1'b0);
        mem_ack(2, 32'hCAFE_BABE, 1'b0, 1'b1, 1'b1, 5'd16, 32'h0000_0000);
        send_load(3'b010, 2'd0, 5'd0, 1'b1, 1'b0);
        mem_ack(1, 32'h1111_2222, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0);

        send_load(3'b010, 2'd1, 5'd17, 1'b1, 1'b1);
        send_load(3'b001, 2'd1, 5'd18, 1'b1, 1'b1);
        send_load(3'b101, 2'd3, 5'd19, 1'b1, 1'b1);

        // Flush a pending load, then ack it later.
        send_load(3'b010, 2'd0, 5'd20, 1'b1, 1'b0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        mem_ack(2, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        send_load(3'b010, 2'd0, 5'd21, 1'b1, 1'b0);
        mem_ack(2, 32'h5555_AAAA, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        // The kill must not leak into the next load.
        send_load(3'b100, 2'd2, 5'd22, 1'b1, 1'b0);
        mem_ack(1, 32'h00C3_0000, 1'b0, 1'b1, 1'b1, 5'd22, 32'h0000_00C3);

        // Back-to-back: new instruction accepted the cycle after the ack.
        send_load(3'b001, 2'd0, 5'd23, 1'b1, 1'b0);
        tick();
        i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_9001;
        exp_q.push_back({5'd23, 32'hFFFF_9001});
        exp_instret = exp_instret + 32'd1;
        tick();
        i_mem_ack = 1'b0;
        chk("b2b_ready", {31'd0, o_ex_ready}, 32'd1);
        i_ex_valid = 1'b1; i_ex_is_load = 1'b0; i_ex_rd_we = 1'b1;
        i_ex_rd_addr = 5'd24; i_ex_result = 32'h0F0F_0F0F;
        exp_q.push_back({5'd24, 32'h0F0F_0F0F});
        exp_instret = exp_instret + 32'd1;
        tick();
        i_ex_valid = 1'b0;
        tick();
        after_op("b2b");

        // Reset while a load is pending; a late ack must be ignored.
        send_load(3'b000, 2'd0, 5'd25, 1'b1, 1'b0);
        tick();
        i_rst_n = 1'b0;
        #2;
        exp_instret = RST_INSTRET;
        chk("rst_mid_ready", {31'd0, o_ex_ready}, 32'd1);
        chk("rst_mid_instret", o_instret, RST_INSTRET);
        tick();
        i_rst_n = 1'b1;
        tick();
        i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_0042;
        tick();
        i_mem_ack = 1'b0;
        tick();
        after_op("late_ack");
        chk("late_ack_ready", {31'd0, o_ex_ready}, 32'd1);

        send_alu(1'b1, 5'd31, 32'h7654_3210);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
